// File: rtl/soml_pkg.sv
// Shared SOML definitions: component format, saturation limits, encoder FSM
// encoding and lane pack/unpack helpers used by both encoder and decoder.
package soml_pkg;

  localparam int DW     = 16;
  localparam int NL     = 4;
  localparam int CW     = DW * NL;
  localparam int Q_INT  = 2;
  localparam int Q_FRAC = 13;

  localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DW-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL0 = 2'd1,
    COL1 = 2'd2
  } state_e;

  function automatic logic [DW-1:0] get_lane(input logic [CW-1:0] col,
                                             input int unsigned   k);
    return col[DW*k +: DW];
  endfunction

  function automatic logic [CW-1:0] set_lane(input logic [CW-1:0] col,
                                             input int unsigned   k,
                                             input logic [DW-1:0] val);
    logic [CW-1:0] res;
    res = col;
    res[DW*k +: DW] = val;
    return res;
  endfunction

endpackage

// File: rtl/soml_sat_neg.sv
// Combinational two's complement negate that clamps the most negative value
// to the most positive one instead of wrapping.
module soml_sat_neg #(
  parameter int DW = soml_pkg::DW
) (
  input  logic [DW-1:0] a,
  output logic [DW-1:0] y
);

  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};

  assign y = (a == MIN_VAL) ? MAX_VAL : -a;

endmodule

// File: rtl/soml_stbc_encoder.sv
// Double-Alamouti space-time encoder: one 4-symbol group in, two packed
// 4-lane columns out (slot 0 then slot 1) over a valid/ready handshake.
module soml_stbc_encoder
  import soml_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] sym_r,
  input  logic [CW-1:0] sym_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] outcol_r,
  output logic [CW-1:0] outcol_i,
  output logic          out_col,
  output logic          frame_done,
  output logic [15:0]   frame_cnt
);

  state_e        state_q, state_d;
  logic [CW-1:0] sym_r_q, sym_r_d;
  logic [CW-1:0] sym_i_q, sym_i_d;
  logic [CW-1:0] outcol_r_q, outcol_r_d;
  logic [CW-1:0] outcol_i_q, outcol_i_d;
  logic          out_col_q, out_col_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [DW-1:0] neg_in  [NL];
  logic [DW-1:0] neg_out [NL];
  logic [CW-1:0] col1_r, col1_i;

  // Each lane pair (x, y) maps to (-conj(y), conj(x)); only y.re and x.im negate.
  always_comb begin
    for (int p = 0; p < NL/2; p++) begin
      neg_in[2*p]   = get_lane(sym_r_q, 2*p + 1);
      neg_in[2*p+1] = get_lane(sym_i_q, 2*p);
    end
  end

  for (genvar n = 0; n < NL; n++) begin : g_neg
    soml_sat_neg #(.DW(DW)) u_neg (
      .a (neg_in[n]),
      .y (neg_out[n])
    );
  end

  always_comb begin
    col1_r = '0;
    col1_i = '0;
    for (int p = 0; p < NL/2; p++) begin
      col1_r = set_lane(col1_r, 2*p,     neg_out[2*p]);
      col1_i = set_lane(col1_i, 2*p,     get_lane(sym_i_q, 2*p + 1));
      col1_r = set_lane(col1_r, 2*p + 1, get_lane(sym_r_q, 2*p));
      col1_i = set_lane(col1_i, 2*p + 1, neg_out[2*p+1]);
    end
  end

  assign in_ready = (state_q == IDLE) || ((state_q == COL1) && out_ready);

  always_comb begin
    state_d      = state_q;
    sym_r_d      = sym_r_q;
    sym_i_d      = sym_i_q;
    outcol_r_d   = outcol_r_q;
    outcol_i_d   = outcol_i_q;
    out_col_d    = out_col_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sym_r_d    = sym_r;
          sym_i_d    = sym_i;
          outcol_r_d = sym_r;
          outcol_i_d = sym_i;
          out_col_d  = 1'b0;
          state_d    = COL0;
        end
      end
      COL0: begin
        if (out_ready) begin
          outcol_r_d = col1_r;
          outcol_i_d = col1_i;
          out_col_d  = 1'b1;
          state_d    = COL1;
        end
      end
      COL1: begin
        if (out_ready) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          out_col_d    = 1'b0;
          if (in_valid) begin
            sym_r_d    = sym_r;
            sym_i_d    = sym_i;
            outcol_r_d = sym_r;
            outcol_i_d = sym_i;
            state_d    = COL0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sym_r_q      <= '0;
      sym_i_q      <= '0;
      outcol_r_q   <= '0;
      outcol_i_q   <= '0;
      out_col_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sym_r_q      <= sym_r_d;
      sym_i_q      <= sym_i_d;
      outcol_r_q   <= outcol_r_d;
      outcol_i_q   <= outcol_i_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid  = (state_q != IDLE);
  assign outcol_r   = outcol_r_q;
  assign outcol_i   = outcol_i_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_soml_stbc_encoder.sv
// Directed and randomized bench for soml_stbc_encoder, checked against a
// complex-arithmetic model of the double Alamouti codeword.
module tb_soml_stbc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sym_r;
  logic [63:0] sym_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] outcol_r;
  logic [63:0] outcol_i;
  logic        out_col;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] expCnt     = 16'd0;

  soml_stbc_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sym_r      (sym_r),
    .sym_i      (sym_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outcol_r   (outcol_r),
    .outcol_i   (outcol_i),
    .out_col    (out_col),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Negation on the integer line, clamped to the Q2.13 range
  function automatic logic [15:0] mneg(input logic [15:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  // Slot 0 sends (x, y); slot 1 sends (-conj(y), conj(x)) for each symbol pair
  task automatic modelCols(input  logic [63:0] r, input logic [63:0] i,
                           output logic [63:0] c0r, output logic [63:0] c0i,
                           output logic [63:0] c1r, output logic [63:0] c1i);
    logic [15:0] xr, xi, yr, yi;
    c0r = r;
    c0i = i;
    c1r = '0;
    c1i = '0;
    for (int p = 0; p < 2; p++) begin
      xr = r[32*p +: 16];
      xi = i[32*p +: 16];
      yr = r[32*p+16 +: 16];
      yi = i[32*p+16 +: 16];
      c1r[32*p +: 16]    = mneg(yr);
      c1i[32*p +: 16]    = yi;
      c1r[32*p+16 +: 16] = xr;
      c1i[32*p+16 +: 16] = mneg(xi);
    end
  endtask

  function automatic logic [15:0] randComp();
    if ($urandom_range(0, 3) == 0) return 16'h8000;
    return 16'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [63:0] r, input logic [63:0] i,
                               input logic v);
    sym_r    = r;
    sym_i    = i;
    in_valid = v;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkColumn(input string tag, input logic [63:0] er,
                             input logic [63:0] ei, input logic ecol);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".col"},   64'(out_col),   64'(ecol));
    checkOutput({tag, ".re"},    outcol_r,       er);
    checkOutput({tag, ".im"},    outcol_i,       ei);
  endtask

  // One full codeword with out_ready held high and no follow-on group
  task automatic runFrame(input string tag, input logic [63:0] r,
                          input logic [63:0] i);
    logic [63:0] c0r, c0i, c1r, c1i;
    modelCols(r, i, c0r, c0i, c1r, c1i);
    applyStimulus(r, i, 1'b1);
    out_ready = 1'b1;
    step();
    applyStimulus('0, '0, 1'b0);
    checkColumn({tag, ".c0"}, c0r, c0i, 1'b0);
    step();
    checkColumn({tag, ".c1"}, c1r, c1i, 1'b1);
    checkOutput({tag, ".done_early"}, 64'(frame_done), 64'd0);
    step();
    expCnt++;
    checkOutput({tag, ".done"},  64'(frame_done), 64'd1);
    checkOutput({tag, ".cnt"},   64'(frame_cnt),  64'(expCnt));
    checkOutput({tag, ".idle"},  64'(out_valid),  64'd0);
  endtask

  logic [63:0] gr [8];
  logic [63:0] gi [8];
  logic [63:0] er, ei, e0r, e0i, e1r, e1i;
  logic [63:0] br, bi;

  initial begin
    // Reset held two cycles, then ten idle cycles
    rst = 1'b1;
    out_ready = 1'b0;
    applyStimulus('0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst.out_valid",  64'(out_valid),  64'd0);
    checkOutput("rst.in_ready",   64'(in_ready),   64'd1);
    checkOutput("rst.outcol_r",   outcol_r,        64'd0);
    checkOutput("rst.outcol_i",   outcol_i,        64'd0);
    checkOutput("rst.out_col",    64'(out_col),    64'd0);
    checkOutput("rst.frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst.frame_cnt",  64'(frame_cnt),  64'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      checkOutput("idle.out_valid", 64'(out_valid), 64'd0);
      checkOutput("idle.in_ready",  64'(in_ready),  64'd1);
      checkOutput("idle.outcol_r",  outcol_r,       64'd0);
    end

    // Basic codeword with hand-computed slot values
    $display("[TB] basic codeword");
    br = {16'h0400, 16'h3000, 16'h2000, 16'h1000};
    bi = {16'hF000, 16'h0300, 16'h0200, 16'h0100};
    applyStimulus(br, bi, 1'b1);
    out_ready = 1'b1;
    step();
    applyStimulus('0, '0, 1'b0);
    checkOutput("basic.c0r", outcol_r, 64'h0400_3000_2000_1000);
    checkOutput("basic.c0i", outcol_i, 64'hF000_0300_0200_0100);
    checkOutput("basic.col0", 64'(out_col), 64'd0);
    step();
    checkOutput("basic.c1r", outcol_r, 64'h3000_FC00_1000_E000);
    checkOutput("basic.c1i", outcol_i, 64'hFD00_F000_FF00_0200);
    checkOutput("basic.col1", 64'(out_col), 64'd1);
    step();
    expCnt++;
    checkOutput("basic.done", 64'(frame_done), 64'd1);
    checkOutput("basic.cnt",  64'(frame_cnt),  64'(expCnt));
    step();
    checkOutput("basic.done_once", 64'(frame_done), 64'd0);

    // Saturation corner: negating 0x8000 clamps, negating 0 stays 0
    $display("[TB] saturation");
    applyStimulus({32'h0, 16'h8000, 16'h0000}, {32'h0, 16'h8000, 16'h0000}, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0);
    step();
    checkOutput("sat.lane0_re", 64'(outcol_r[15:0]),  64'h7FFF);
    checkOutput("sat.lane0_im", 64'(outcol_i[15:0]),  64'h8000);
    checkOutput("sat.lane1_im", 64'(outcol_i[31:16]), 64'h0000);
    step();
    expCnt++;
    applyStimulus({32'h0, 16'h8000, 16'h0000}, {32'h0, 16'h8000, 16'h8000}, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0);
    step();
    checkOutput("sat2.lane1_im", 64'(outcol_i[31:16]), 64'h7FFF);
    step();
    expCnt++;
    checkOutput("sat2.cnt", 64'(frame_cnt), 64'(expCnt));

    // Randomized single frames
    for (int f = 0; f < 6; f++) begin
      runFrame("rand", {randComp(), randComp(), randComp(), randComp()},
                       {randComp(), randComp(), randComp(), randComp()});
    end

    // Backpressure in both slots
    $display("[TB] backpressure");
    br = {randComp(), randComp(), randComp(), randComp()};
    bi = {randComp(), randComp(), randComp(), randComp()};
    modelCols(br, bi, e0r, e0i, e1r, e1i);
    applyStimulus(br, bi, 1'b1);
    out_ready = 1'b0;
    step();
    applyStimulus('0, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkColumn("bp.c0", e0r, e0i, 1'b0);
      checkOutput("bp.c0.in_ready", 64'(in_ready),   64'd0);
      checkOutput("bp.c0.done",     64'(frame_done), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkColumn("bp.c1", e1r, e1i, 1'b1);
      checkOutput("bp.c1.in_ready", 64'(in_ready),   64'd0);
      checkOutput("bp.c1.done",     64'(frame_done), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp.in_ready_release", 64'(in_ready), 64'd1);
    step();
    expCnt++;
    checkOutput("bp.done", 64'(frame_done), 64'd1);
    checkOutput("bp.cnt",  64'(frame_cnt),  64'(expCnt));

    // Eight groups back to back: one column per cycle
    $display("[TB] back-to-back");
    for (int g = 0; g < 8; g++) begin
      gr[g] = {randComp(), randComp(), randComp(), randComp()};
      gi[g] = {randComp(), randComp(), randComp(), randComp()};
    end
    out_ready = 1'b1;
    applyStimulus(gr[0], gi[0], 1'b1);
    for (int c = 0; c < 16; c++) begin
      step();
      if (c % 2 == 0) begin
        if (c / 2 + 1 < 8) applyStimulus(gr[c/2+1], gi[c/2+1], 1'b1);
        else               applyStimulus('0, '0, 1'b0);
      end
      modelCols(gr[c/2], gi[c/2], e0r, e0i, e1r, e1i);
      er = (c % 2 == 0) ? e0r : e1r;
      ei = (c % 2 == 0) ? e0i : e1i;
      checkColumn("b2b", er, ei, 1'(c % 2));
      if (c >= 2 && c % 2 == 0) expCnt++;
      checkOutput("b2b.done", 64'(frame_done), 64'((c >= 2 && c % 2 == 0) ? 1 : 0));
      checkOutput("b2b.cnt",  64'(frame_cnt),  64'(expCnt));
    end
    step();
    expCnt++;
    checkOutput("b2b.last_done", 64'(frame_done), 64'd1);
    checkOutput("b2b.cnt_final", 64'(frame_cnt),  64'(expCnt));
    checkOutput("b2b.idle",      64'(out_valid),  64'd0);

    // Reset while slot 1 is stalled abandons the codeword
    $display("[TB] reset mid-frame");
    applyStimulus({randComp(), randComp(), randComp(), randComp()},
                  {randComp(), randComp(), randComp(), randComp()}, 1'b1);
    out_ready = 1'b1;
    step();
    applyStimulus('0, '0, 1'b0);
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    expCnt = 16'd0;
    checkOutput("mid.out_valid", 64'(out_valid),  64'd0);
    checkOutput("mid.cnt",       64'(frame_cnt),  64'd0);
    checkOutput("mid.done",      64'(frame_done), 64'd0);
    step();
    checkOutput("mid.done_after", 64'(frame_done), 64'd0);
    runFrame("post_rst", {randComp(), randComp(), randComp(), randComp()},
                         {randComp(), randComp(), randComp(), randComp()});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
